// File: rtl/sram_sp_bw_model.sv
// Single-port synchronous SRAM behavioural model with per-byte write mask,
// 1- or 2-edge read latency with a QVALID strobe, and an optional
// post-reset zero-fill sequencer that holds READY low until it finishes.
module sram_sp_bw_model #(
   parameter int BITS          = 64,
   parameter int WORD_DEPTH    = 512,
   parameter int ADD_WIDTH     = 9,
   parameter int READ_LATENCY  = 1,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CEB,
   input  logic                 WEB,
   input  logic [ADD_WIDTH-1:0] A,
   input  logic [BITS-1:0]      D,
   input  logic [BITS/8-1:0]    BWEB,
   output logic [BITS-1:0]      Q,
   output logic                 QVALID,
   output logic                 READY
);

   localparam int NBYTES = BITS / 8;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // Illegal parameter combinations stop elaboration.
   if (BITS % 8 != 0) begin : g_chk_bits
      $fatal(1, "sram_sp_bw_model: BITS must be a multiple of 8");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
      $fatal(1, "sram_sp_bw_model: READ_LATENCY must be 1 or 2");
   end
   if ((64'(1) << ADD_WIDTH) < 64'(WORD_DEPTH)) begin : g_chk_addr
      $fatal(1, "sram_sp_bw_model: ADD_WIDTH too small for WORD_DEPTH");
   end

   state_t                 state_q, state_d;
   logic [ADD_WIDTH-1:0]   cnt_q;
   logic                   init_we;
   logic                   init_last;
   logic                   accept;
   logic                   addr_ok;
   logic                   wr_en;
   logic                   rd_en;

   logic [BITS-1:0]        mem [WORD_DEPTH];
   logic [BITS-1:0]        pipe_data [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_vld;

   // Addresses at or above WORD_DEPTH exist on the bus but not in the array.
   assign addr_ok   = 32'(A) < WORD_DEPTH;
   assign init_last = 32'(cnt_q) == WORD_DEPTH - 1;
   // Requests are only honoured in RUN; anything earlier is dropped, not queued.
   assign accept    = READY && !RST && !CEB;
   assign wr_en     = accept && !WEB && addr_ok;
   assign rd_en     = accept && WEB;

   // Next-state and READY/zero-fill strobe decode.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      READY   = 1'b0;
      init_we = 1'b0;
      case (state_q)
         ST_RESET: state_d = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         ST_INIT: begin
            init_we = 1'b1;
            if (init_last) state_d = ST_RUN;
         end
         ST_RUN:   READY = 1'b1;
         default:  state_d = ST_RESET;
      endcase
   end

   // State register and zero-fill word counter.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every block
      // sampling it on this edge sees the pre-edge value.
      if (RST) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (init_we) cnt_q <= init_last ? '0 : cnt_q + 1'b1;
      end
   end

   // Array update: zero-fill during INIT, byte-masked writes during RUN.
   always_ff @(posedge CLK) begin
      // NOTE: the array has no reset; RST leaves its contents untouched and
      // only the zero-fill sequencer clears it.
      if (!RST) begin
         if (init_we) begin
            mem[cnt_q] <= '0;
         end else if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
               if (!BWEB[i]) mem[A][8*i +: 8] <= D[8*i +: 8];
            end
         end
      end
   end

   // Read data pipeline: the array is captured on the request edge, so a
   // later write cannot alter a read already in flight.
   always_ff @(posedge CLK) begin
      if (rd_en) pipe_data[0] <= addr_ok ? mem[A] : '0;
      for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
   end

   // Read valid pipeline and output register; Q only moves on a returning read.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pipe_vld <= '0;
         Q        <= '0;
         QVALID   <= 1'b0;
      end else begin
         pipe_vld[0] <= rd_en;
         for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
         QVALID <= pipe_vld[READ_LATENCY-1];
         if (pipe_vld[READ_LATENCY-1]) Q <= pipe_data[READ_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_sram_sp_bw_model.sv
// Directed bench for sram_sp_bw_model. Four instances share one stimulus:
//   u_l1   : defaults (512x64, latency 1, zero-fill)
//   u_l2   : latency 2
//   u_d300 : WORD_DEPTH=300 (non-power-of-2)
//   u_noin : INIT_ON_RESET=0
// Expected values are hand-computed constants.
module tb_sram_sp_bw_model;

   logic        CLK;
   logic        RST;
   logic        CEB;
   logic        WEB;
   logic [8:0]  A;
   logic [63:0] D;
   logic [7:0]  BWEB;

   logic [63:0] q1, q2, q3, q4;
   logic        qv1, qv2, qv3, qv4;
   logic        rdy1, rdy2, rdy3, rdy4;

   int n_checks = 0;
   int n_err    = 0;

   sram_sp_bw_model #(.READ_LATENCY(1)) u_l1 (
      .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
      .Q(q1), .QVALID(qv1), .READY(rdy1)
   );

   sram_sp_bw_model #(.READ_LATENCY(2)) u_l2 (
      .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
      .Q(q2), .QVALID(qv2), .READY(rdy2)
   );

   sram_sp_bw_model #(.WORD_DEPTH(300), .ADD_WIDTH(9)) u_d300 (
      .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
      .Q(q3), .QVALID(qv3), .READY(rdy3)
   );

   sram_sp_bw_model #(.INIT_ON_RESET(0)) u_noin (
      .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
      .Q(q4), .QVALID(qv4), .READY(rdy4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled and inputs changed 1ns later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      CEB  = 1'b1;
      WEB  = 1'b1;
      BWEB = 8'hFF;
   endtask

   task automatic do_write(input logic [8:0] a, input logic [63:0] d, input logic [7:0] bweb);
      CEB = 1'b0; WEB = 1'b0; A = a; D = d; BWEB = bweb;
      tick();
      idle();
   endtask

   // Read at edge N: latency-1 instances checked after N+1, latency-2 after N+2,
   // where the latency-1 strobe must already be gone and Q must be holding.
   task automatic read_check(input string tag, input logic [8:0] a,
                             input logic [63:0] e_full, input logic [63:0] e_d300);
      CEB = 1'b0; WEB = 1'b1; A = a;
      tick();
      idle();
      tick();
      check({tag, "_q_l1"},    q1,  e_full);
      check({tag, "_qv_l1"},   qv1, 1);
      check({tag, "_q_d300"},  q3,  e_d300);
      check({tag, "_qv_d300"}, qv3, 1);
      tick();
      check({tag, "_q_l2"},      q2,  e_full);
      check({tag, "_qv_l2"},     qv2, 1);
      check({tag, "_qv_l1_off"}, qv1, 0);
      check({tag, "_q_l1_hold"}, q1,  e_full);
   endtask

   // RST must already be low. Counts edges from the first edge that sees RST=0
   // until each READY rises; latency = edges after that first edge.
   task automatic wait_ready(input string tag, input bit poke,
                             input int e_full, input int e_d300);
      int  lat1 = -1, lat2 = -1, lat3 = -1, lat4 = -1;
      bit  any_qv = 0, any_q = 0;
      for (int n = 1; n <= 700; n++) begin
         idle();
         if (poke && n == 20) begin  // write during INIT: must be dropped
            CEB = 1'b0; WEB = 1'b0; A = 9'd2; D = '1; BWEB = 8'h00;
         end
         if (poke && n == 21) begin  // read during INIT: must be dropped
            CEB = 1'b0; WEB = 1'b1; A = 9'd2;
         end
         tick();
         if (lat1 < 0 && rdy1) lat1 = n - 1;
         if (lat2 < 0 && rdy2) lat2 = n - 1;
         if (lat3 < 0 && rdy3) lat3 = n - 1;
         if (lat4 < 0 && rdy4) lat4 = n - 1;
         if (qv1 || qv2 || qv3) any_qv = 1;
         if ((q1 | q2 | q3) != 0) any_q = 1;
         if (lat1 >= 0 && lat2 >= 0 && lat3 >= 0 && lat4 >= 0) break;
      end
      idle();
      check({tag, "_ready_lat_l1"},   64'(lat1), 64'(e_full));
      check({tag, "_ready_lat_l2"},   64'(lat2), 64'(e_full));
      check({tag, "_ready_lat_d300"}, 64'(lat3), 64'(e_d300));
      check({tag, "_ready_lat_noin"}, 64'(lat4), 0);
      check({tag, "_no_qvalid_init"}, 64'(any_qv), 0);
      check({tag, "_q_zero_init"},    64'(any_q), 0);
   endtask

   initial begin
      RST = 1'b1; A = '0; D = '0;
      idle();

      // Reset state.
      repeat (3) tick();
      check("rst_q_l1",    q1,   0);
      check("rst_qv_l1",   qv1,  0);
      check("rst_rdy_l1",  rdy1, 0);
      check("rst_q_l2",    q2,   0);
      check("rst_rdy_l2",  rdy2, 0);
      check("rst_rdy_noin", rdy4, 0);
      check("rst_qv_noin", qv4,  0);

      // Zero-fill timing; requests during INIT are dropped.
      RST = 1'b0;
      wait_ready("init", 1'b1, 512, 300);

      // Top word (0x1FF) reads as zero; out of range for the 300-deep instance.
      read_check("top_word", 9'h1FF, 64'h0, 64'h0);
      // Word 2 was zero-filled; the write attempted during INIT had no effect.
      read_check("init_drop", 9'd2, 64'h0, 64'h0);

      // Byte-masked writes: BWEB=0xF0 enables bytes 0..3.
      do_write(9'd5, 64'h1122334455667788, 8'h00);
      do_write(9'd5, 64'hFFFFFFFFFFFFFFFF, 8'hF0);
      read_check("bmask_f0", 9'd5, 64'h11223344FFFFFFFF, 64'h11223344FFFFFFFF);
      // BWEB=0x5A enables bytes 0,2,5,7.
      do_write(9'd5, 64'h0, 8'h5A);
      read_check("bmask_5a", 9'd5, 64'h00220044FF00FF00, 64'h00220044FF00FF00);
      // BWEB all ones is a no-op.
      do_write(9'd5, 64'h0, 8'hFF);
      read_check("bmask_ff", 9'd5, 64'h00220044FF00FF00, 64'h00220044FF00FF00);

      // Streaming: preload 1..4, then four back-to-back reads (edges N..N+3).
      for (int i = 1; i <= 4; i++) do_write(9'(i), 64'(17 * i), 8'h00);
      for (int k = 0; k < 8; k++) begin
         int j1, j2;
         idle();
         if (k < 4) begin
            CEB = 1'b0; WEB = 1'b1; A = 9'(k + 1);
         end
         tick();  // now just after edge N+k
         j1 = (k > 4) ? 4 : k;
         j2 = (k > 5) ? 4 : k - 1;
         if (k >= 1) begin
            check($sformatf("stream_qv_l1_%0d", k), qv1, (k <= 4) ? 1 : 0);
            check($sformatf("stream_q_l1_%0d", k),  q1,  64'(17 * j1));
         end
         check($sformatf("stream_qv_l2_%0d", k), qv2, (k >= 2 && k <= 5) ? 1 : 0);
         if (k >= 2) check($sformatf("stream_q_l2_%0d", k), q2, 64'(17 * j2));
      end
      idle();

      // Write then read on the next edge returns the new data.
      do_write(9'd7, 64'hAB, 8'h00);
      read_check("wr_then_rd", 9'd7, 64'hAB, 64'hAB);
      // Read at N, write at N+1: the in-flight read keeps the old value.
      CEB = 1'b0; WEB = 1'b1; A = 9'd7;
      tick();
      CEB = 1'b0; WEB = 1'b0; A = 9'd7; D = 64'hCD; BWEB = 8'h00;
      tick();
      idle();
      check("rd_then_wr_q_l1",  q1,  64'hAB);
      check("rd_then_wr_qv_l1", qv1, 1);
      tick();
      check("rd_then_wr_q_l2",  q2,  64'hAB);
      check("rd_then_wr_qv_l2", qv2, 1);
      read_check("rd_then_wr_new", 9'd7, 64'hCD, 64'hCD);

      // Non-power-of-2 depth: 310 is out of range only for the 300-deep instance.
      do_write(9'd310, 64'hCAFE, 8'h00);
      read_check("oor_310", 9'd310, 64'hCAFE, 64'h0);
      do_write(9'd299, 64'h0123456789ABCDEF, 8'h00);
      read_check("last_299", 9'd299, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);

      // Reset with reads in flight: no strobe, Q cleared.
      do_write(9'd200, 64'h5555, 8'h00);
      CEB = 1'b0; WEB = 1'b1; A = 9'd5;
      tick();
      idle();
      RST = 1'b1;
      tick();
      check("rst_fl_qv_l1",  qv1,  0);
      check("rst_fl_q_l1",   q1,   0);
      check("rst_fl_rdy_l1", rdy1, 0);
      check("rst_fl_q_l2",   q2,   0);
      tick();
      check("rst_fl_qv_l2",  qv2,  0);
      check("rst_fl_q_l2b",  q2,   0);

      // Reset again at INIT cnt=100 (edge 102 after release), then full restart.
      RST = 1'b0;
      repeat (101) tick();
      RST = 1'b1;
      tick();
      check("mid_init_rdy_l1", rdy1, 0);
      check("mid_init_q_l1",   q1,   0);
      RST = 1'b0;
      wait_ready("reinit", 1'b0, 512, 300);
      read_check("reinit_a200", 9'd200, 64'h0, 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
